serial_add_ctrl: RTL and testbench

- Sequencer that computes a WIDTH-bit addition bit-serially, LSB first, over WIDTH clock cycles.
- Uses a single shared 1-bit full-adder slice, built from two half-adder cells and an OR gate.
- Accepts operands with a start/busy handshake and returns sum, carry-out and a one-cycle done pulse.
- Serves as the area-minimal adder controller for multi-bit datapaths in this library.

---
 rtl/serial_add_pkg.sv | 12 +
 rtl/serial_add_ctrl_if.sv | 27 ++
 rtl/serial_fa_slice.sv | 19 +
 rtl/serial_half_adder.sv | 12 +
 rtl/serial_add_ctrl.sv | 111 +++++++++++
 tb/tb_serial_add_ctrl.sv | 191 +++++++++++++++++++
 6 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result bundle of the serial adder. Handshake: the master raises start with a/b;
// the request is taken only while busy and done are both low, and done pulses once per result.
interface serial_add_ctrl_if #(
    parameter int WIDTH = serial_add_pkg::DEFAULT_WIDTH
) ();
    import serial_add_pkg::*;

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    state_e           state;

    modport master (
        output start, a, b,
        input  busy, done, sum, cout, state
    );

    modport slave (
        input  start, a, b,
        output busy, done, sum, cout, state
    );

endinterface

// File: rtl/serial_fa_slice.sv
// Combinational 1-bit full adder made of two half-adder cells and an OR.
module serial_fa_slice (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic co
);

    logic s1;
    logic c1;
    logic c2;

    serial_half_adder u_ha0 (.x(x),  .y(y),   .s(s1), .c(c1));
    serial_half_adder u_ha1 (.x(s1), .y(cin), .s(s),  .c(c2));

    assign co = c1 | c2;

endmodule

// File: rtl/serial_half_adder.sv
// One-bit half-adder cell.
module serial_half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared full-adder slice consumes one operand bit per cycle, LSB first.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    serial_add_ctrl_if.slave    bus
);

    localparam int             CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] res_next;

    serial_fa_slice u_fa (
        .x   (opa_q[0]),
        .y   (opb_q[0]),
        .cin (carry_q),
        .s   (fa_s),
        .co  (fa_co)
    );

    // Result fills from the top so the first (LSB) slice output ends at bit 0 after WIDTH shifts.
    assign res_next = WIDTH'({fa_s, res_q} >> 1);

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    opa_d   = bus.a;
                    opb_d   = bus.b;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                res_d   = res_next;
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    sum_d   = res_next;
                    cout_d  = fa_co;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl at widths 8, 2 and 1 against an arithmetic timing/result model.
module tb_serial_add_ctrl;

    logic clk;
    logic rst;

    serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_add_ctrl_if #(.WIDTH(2)) bus2 ();
    serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_add_ctrl #(.WIDTH(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
    serial_add_ctrl #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        int         acc_edge;
        int         done_edge;
    } exp_t;

    exp_t       exp_q[3][$];
    int         wd[3];
    int         free_edge[3];
    logic [7:0] last_sum[3];
    logic       last_cout[3];
    int         cyc;
    bit         chk_en;
    int         n_cmp;
    int         n_err;

    logic [7:0] sum_w[3];
    logic       cout_w[3];
    logic       busy_w[3];
    logic       done_w[3];

    assign sum_w[0] = bus8.sum;
    assign sum_w[1] = {6'b0, bus2.sum};
    assign sum_w[2] = {7'b0, bus1.sum};
    assign cout_w[0] = bus8.cout;
    assign cout_w[1] = bus2.cout;
    assign cout_w[2] = bus1.cout;
    assign busy_w[0] = bus8.busy;
    assign busy_w[1] = bus2.busy;
    assign busy_w[2] = bus1.busy;
    assign done_w[0] = bus8.done;
    assign done_w[1] = bus2.done;
    assign done_w[2] = bus1.done;

    task automatic chk(input string name, input int i, input logic [8:0] act, input logic [8:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s dut%0d cyc %0d: got %h expected %h", name, i, cyc, act, expv);
        end
    endtask

    // driver: one cycle of stimulus for dut i, applied on the falling edge
    task automatic step(input int i, input bit st, input logic [7:0] a, input logic [7:0] b, input bit r);
        int         e;
        logic [8:0] mask;
        logic [8:0] full;
        exp_t       x;
        @(negedge clk);
        rst = r;
        bus8.start = 1'b0;
        bus2.start = 1'b0;
        bus1.start = 1'b0;
        case (i)
            0: begin bus8.start = st; bus8.a = a;      bus8.b = b;      end
            1: begin bus2.start = st; bus2.a = a[1:0]; bus2.b = b[1:0]; end
            default: begin bus1.start = st; bus1.a = a[0]; bus1.b = b[0]; end
        endcase
        e = cyc + 1;
        if (r) begin
            chk_en = 1'b1;
            for (int j = 0; j < 3; j++) begin
                exp_q[j].delete();
                last_sum[j]  = 8'h00;
                last_cout[j] = 1'b0;
                free_edge[j] = e + 1;
            end
        end else if (st && e >= free_edge[i]) begin
            mask = (9'd1 << wd[i]) - 9'd1;
            full = ({1'b0, a} & mask) + ({1'b0, b} & mask);
            x.sum       = 8'(full & mask);
            x.cout      = full[wd[i]];
            x.acc_edge  = e;
            x.done_edge = e + wd[i];
            exp_q[i].push_back(x);
            free_edge[i] = e + wd[i] + 2;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 1'b0, 8'($urandom), 8'($urandom), 1'b0);
    endtask

    // one accepted operation followed by junk start/operand activity until the unit is free again
    task automatic run_op(input int i, input logic [7:0] a, input logic [7:0] b);
        step(i, 1'b1, a, b, 1'b0);
        for (int k = 1; k <= wd[i] + 1; k++)
            step(i, (k <= wd[i]) ? 1'($urandom_range(0, 1)) : 1'b0, 8'($urandom), 8'($urandom), 1'b0);
    endtask

    // monitor / scoreboard
    always @(posedge clk) begin
        bit exp_done;
        bit exp_busy;
        cyc = cyc + 1;
        #1;
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                exp_done = (exp_q[i].size() > 0) && (exp_q[i][0].done_edge == cyc);
                exp_busy = (exp_q[i].size() > 0) && (cyc >= exp_q[i][0].acc_edge) &&
                           (cyc < exp_q[i][0].done_edge);
                chk("done", i, {8'h00, done_w[i]}, {8'h00, exp_done});
                chk("busy", i, {8'h00, busy_w[i]}, {8'h00, exp_busy});
                if (exp_done) begin
                    last_sum[i]  = exp_q[i][0].sum;
                    last_cout[i] = exp_q[i][0].cout;
                    void'(exp_q[i].pop_front());
                end
                chk("sum", i, {1'b0, sum_w[i]}, {1'b0, last_sum[i]});
                chk("cout", i, {8'h00, cout_w[i]}, {8'h00, last_cout[i]});
            end
        end
    end

    initial begin
        rst = 1'b0;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
        bus2.start = 1'b0; bus2.a = '0; bus2.b = '0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0;
        wd[0] = 8; wd[1] = 2; wd[2] = 1;
        cyc = 0; chk_en = 1'b0; n_cmp = 0; n_err = 0;
        for (int j = 0; j < 3; j++) begin
            free_edge[j] = 0; last_sum[j] = 8'h00; last_cout[j] = 1'b0;
        end

        repeat (2) step(0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'b1);
        idle(3);

        run_op(0, 8'h0F, 8'h01);
        run_op(0, 8'hFF, 8'h01);
        run_op(0, 8'hA5, 8'h5A);
        idle(2);

        // reset lands on the fifth edge of a running addition
        step(0, 1'b1, 8'h33, 8'h44, 1'b0);
        repeat (3) step(0, 1'b0, 8'($urandom), 8'($urandom), 1'b0);
        step(0, 1'b0, 8'($urandom), 8'($urandom), 1'b1);
        idle(2);
        run_op(0, 8'h80, 8'h80);

        repeat (30) step(0, 1'b1, 8'h01, 8'h02, 1'b0);
        idle(10);

        for (int k = 0; k < 30; k++) begin
            idle($urandom_range(0, 3));
            run_op(0, 8'($urandom), 8'($urandom));
        end

        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                run_op(1, 8'(a), 8'(b));

        run_op(2, 8'h01, 8'h01);
        for (int a = 0; a < 2; a++)
            for (int b = 0; b < 2; b++)
                run_op(2, 8'(a), 8'(b));

        idle(12);
        for (int j = 0; j < 3; j++) begin
            n_cmp++;
            if (exp_q[j].size() != 0) begin
                n_err++;
                $display("FAIL drain dut%0d: got %0d results still pending, expected 0", j, exp_q[j].size());
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
